radix8_booth_seq_mult: RTL and testbench

- Parametrised, iterative radix-8 Booth multiplier; next generation of the team's 16x16 combinational radix-8 Booth multiplier.
- Retires one Booth digit per clock over a shared adder.
- Adds width generalisation, a per-operation signed/unsigned mode and valid/ready handshakes on input and output.
- Sits in the datapath wherever area matters more than single-cycle latency.

---
 rtl/radix8_booth_seq_mult_if.sv | 24 ++
 rtl/radix8_booth_seq_mult.sv | 138 +++++++++++++
 tb/tb_radix8_booth_seq_mult.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/radix8_booth_seq_mult_if.sv
// Operand/product handshake bundle for radix8_booth_seq_mult.
// The source/consumer side uses master and the multiplier uses slave.
interface radix8_booth_seq_mult_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, multiplicand, multiplier, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/radix8_booth_seq_mult.sv
// Iterative radix-8 Booth multiplier, one digit per clock, signed/unsigned per operation.
// Optional macro BOOTH_ZERO_BYPASS_EN: a zero operand skips PRE/RUN and reports 0 immediately.
module radix8_booth_seq_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    radix8_booth_seq_mult_if.slave      bus
);
    localparam int unsigned NDIG = (WIDTH + 3) / 3;
    localparam int unsigned EW   = WIDTH + 1;
    localparam int unsigned TW   = WIDTH + 3;
    localparam int unsigned HW   = WIDTH + 4;
    localparam int unsigned LW   = 3 * NDIG;
    localparam int unsigned LLW  = LW - 3;
    localparam int unsigned BW   = LW + 1;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, PRE, RUN, DONE} state_t;

    state_t                 state;
    logic signed [EW-1:0]   a_reg;
    logic signed [TW-1:0]   m3_reg;
    logic [BW-1:0]          b_reg;
    logic signed [HW-1:0]   acc_hi;
    logic [LLW-1:0]         acc_lo;
    logic [CW-1:0]          cnt;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [PW-1:0]          product_q;

    logic                   a_sign;
    logic                   b_sign;
    logic signed [TW-1:0]   m1;
    logic signed [TW-1:0]   m2;
    logic signed [TW-1:0]   m4;
    logic signed [TW-1:0]   pp_mag;
    logic                   pp_neg;
    logic signed [HW-1:0]   pp_ext;
    logic signed [HW-1:0]   pp;
    logic signed [HW-1:0]   sum;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;

    // Both modes share one datapath by extending operands to WIDTH+1 bits.
    assign a_sign = bus.signed_mode & bus.multiplicand[WIDTH-1];
    assign b_sign = bus.signed_mode & bus.multiplier[WIDTH-1];

    assign m1 = {{2{a_reg[EW-1]}}, a_reg};
    assign m2 = {a_reg[EW-1], a_reg, 1'b0};
    assign m4 = {a_reg, 2'b00};

    // Booth recode of the current window {b[3i+2:3i], b[3i-1]} and accumulate.
    always_comb begin
        pp_mag = '0;
        pp_neg = 1'b0;
        case (b_reg[3:0])
            4'b0001, 4'b0010: pp_mag = m1;
            4'b0011, 4'b0100: pp_mag = m2;
            4'b0101, 4'b0110: pp_mag = m3_reg;
            4'b0111:          pp_mag = m4;
            4'b1000:          begin pp_mag = m4;     pp_neg = 1'b1; end
            4'b1001, 4'b1010: begin pp_mag = m3_reg; pp_neg = 1'b1; end
            4'b1011, 4'b1100: begin pp_mag = m2;     pp_neg = 1'b1; end
            4'b1101, 4'b1110: begin pp_mag = m1;     pp_neg = 1'b1; end
            default:          pp_mag = '0;
        endcase
        pp_ext = {pp_mag[TW-1], pp_mag};
        pp     = pp_neg ? -pp_ext : pp_ext;
        sum    = acc_hi + pp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            m3_reg      <= '0;
            b_reg       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_reg      <= {a_sign, bus.multiplicand};
                        b_reg      <= {{(LW - WIDTH){b_sign}}, bus.multiplier, 1'b0};
                        in_ready_q <= 1'b0;
`ifdef BOOTH_ZERO_BYPASS_EN
                        if (bus.multiplicand == '0 || bus.multiplier == '0) begin
                            product_q   <= '0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= PRE;
                        end
`else
                        state <= PRE;
`endif
                    end
                end
                PRE: begin
                    m3_reg <= m1 + m2;
                    acc_hi <= '0;
                    acc_lo <= '0;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    // Right-shift accumulator: retired bits migrate into acc_lo.
                    acc_hi <= sum >>> 3;
                    acc_lo <= LLW'({sum[2:0], acc_lo} >> 3);
                    b_reg  <= {{3{b_reg[BW-1]}}, b_reg[BW-1:3]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NDIG - 1)) begin
                        product_q   <= PW'({sum, acc_lo});
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_radix8_booth_seq_mult.sv
// Directed bench for radix8_booth_seq_mult at WIDTH=16 with hand-computed products.
// Expected zero-operand latency follows BOOTH_ZERO_BYPASS_EN.
module tb_radix8_booth_seq_mult;
    localparam int LAT = 8;
`ifdef BOOTH_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 8;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    radix8_booth_seq_mult_if #(.WIDTH(16)) bus ();

    radix8_booth_seq_mult #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sm);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_before_op", 64'(bus.in_ready), 64'd1);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.signed_mode  = sm;
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid     = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accepting edge.
    task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_prod);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_prod"}, 64'(bus.product), 64'(exp_prod));
        if (bus.out_ready) begin
            tick();
            check({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        logic seen;
        n_checks = 0;
        n_pass   = 0;
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.signed_mode  = 1'b0;
        bus.out_ready    = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product", 64'(bus.product), 64'd0);
        rst = 1'b0;
        tick();

        start_op(16'd3, 16'd2, 1'b1);
        wait_result("s_3x2", LAT, 32'd6);

        start_op(16'd4660, 16'd0, 1'b1);
        wait_result("s_zero", ZLAT, 32'd0);

        start_op(16'h8000, 16'h8000, 1'b1);
        wait_result("s_min_sq", LAT, 32'h4000_0000);

        start_op(16'hFFF9, 16'd12345, 1'b1);
        wait_result("s_m7x12345", LAT, 32'hFFFE_AE71);

        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        wait_result("u_max_sq", LAT, 32'hFFFE_0001);

        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_result("s_m1_sq", LAT, 32'd1);

        // Backpressure: 100 * -3 = -300 held while new operands wait.
        bus.out_ready = 1'b0;
        start_op(16'd100, 16'hFFFD, 1'b1);
        wait_result("bp", LAT, 32'hFFFF_FED4);
        bus.multiplicand = 16'd9;
        bus.multiplier   = 16'd9;
        bus.signed_mode  = 1'b1;
        bus.in_valid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_prod", 64'(bus.product), 64'hFFFF_FED4);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_accepted", 64'(bus.in_ready), 64'd0);
        wait_result("bp_next", LAT, 32'd81);

        // Reset asserted during cycle 4 of an operation.
        start_op(16'd1234, 16'd77, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_product", 64'(bus.product), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid_rst_no_emit", 64'(seen), 64'd0);

        start_op(16'd5, 16'hFFFB, 1'b1);
        wait_result("s_5xm5", LAT, 32'hFFFF_FFE7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
